// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and sizing helper
// for the oversampling UART receiver and transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int CLOG2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divider producing a one-clk tick every DIV clks,
// with a synchronous restart back to count 0.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = CLOG2(DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q + 1'b1;
    if (tick || restart) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-vote sampling, parity,
// framing and overrun detection, valid/ready word output.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 16000000,
  parameter int BAUD       = 9600,
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int DIV_RAW = CLOCK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int SW      = CLOG2(OVERSAMPLE);
  localparam int BW      = CLOG2(WIDTH + 3);
  localparam int MID     = OVERSAMPLE / 2;

  logic             sync_q, rx_s_q;
  state_e           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [1:0]       samp_q, samp_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             pe_q, pe_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;

  logic tick, restart, commit;
  logic maj, decide, bit_end, par_exp;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    busy_d  = busy_q;
    restart = 1'b0;
    commit  = 1'b0;
    maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) |
              (samp_q[1] & rx_s_q);
    decide  = tick && (s_q == SW'(MID + 1));
    bit_end = tick && (s_q == SW'(OVERSAMPLE - 1));
    par_exp = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;

    if (tick && !(state_q inside {ST_IDLE, ST_BREAK_WAIT})) begin
      s_d = bit_end ? '0 : s_q + 1'b1;
      if (s_q == SW'(MID - 1)) samp_d[0] = rx_s_q;
      if (s_q == SW'(MID))     samp_d[1] = rx_s_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          s_d     = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          busy_d  = 1'b1;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide) shift_d = {maj, shift_q[WIDTH-1:1]};
        if (bit_end) begin
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (decide) perr_d = (maj != par_exp);
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Commit at the last stop decision so a back-to-back start is seen.
        if (decide) begin
          if (!maj) ferr_d = 1'b1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            s_d     = '0;
            state_d = rx_s_q ? ST_IDLE : ST_BREAK_WAIT;
            busy_d  = !rx_s_q;
          end
        end else if (bit_end) begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        pe_d    = perr_q;
        fe_d    = ferr_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= ST_IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= rx_in;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and
// an 8E1 instance driven with serial frames.
module tb_uart_rx_os;

  localparam int CF = 16000000;
  localparam int BR = 1000000;
  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_p, ready_a, ready_p;
  logic [7:0] da, dp;
  logic       va, vp, pa, pp, fa, fp, oa, op, ba, bp;

  exp_t q_a[$];
  exp_t q_p[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   va_cyc = 0;
  int   t0;
  logic va_q   = 1'b0;
  exp_t ea, ep;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(
    .CLOCK_FREQ(CF), .BAUD(BR), .WIDTH(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)
  ) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a),
    .data_out(da), .valid(va), .ready(ready_a),
    .parity_err(pa), .frame_err(fa),
    .overrun(oa), .busy(ba)
  );

  uart_rx_os #(
    .CLOCK_FREQ(CF), .BAUD(BR), .WIDTH(8),
    .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)
  ) dut_p (
    .clk(clk), .rst(rst), .rx_in(rx_p),
    .data_out(dp), .valid(vp), .ready(ready_p),
    .parity_err(pp), .frame_err(fp),
    .overrun(op), .busy(bp)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && va && ready_a) begin
      check("a_pending", q_a.size() > 0, 1);
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        check("a_data", da, ea.d);
        check("a_perr", pa, ea.pe);
        check("a_ferr", fa, ea.fe);
      end
    end
    if (!rst && va && !va_q) va_cyc = cyc;
    va_q = va;
  end

  always @(negedge clk) begin
    if (!rst && vp && ready_p) begin
      check("p_pending", q_p.size() > 0, 1);
      if (q_p.size() > 0) begin
        ep = q_p.pop_front();
        check("p_data", dp, ep.d);
        check("p_perr", pp, ep.pe);
        check("p_ferr", fp, ep.fe);
      end
    end
  end

  task automatic drive(input bit sel, input logic b, input int n);
    if (sel) rx_p = b;
    else     rx_a = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input bit use_par, input logic pb);
    drive(sel, 1'b0, OS);
    for (int i = 0; i < 8; i++) drive(sel, d[i], OS);
    if (use_par) drive(sel, pb, OS);
    drive(sel, 1'b1, OS);
    drive(sel, 1'b1, OS);
  endtask

  initial begin
    rst = 1'b1;
    rx_a = 1'b1;
    rx_p = 1'b1;
    ready_a = 1'b1;
    ready_p = 1'b1;
    #1;
    check("rst_a", {va, pa, fa, oa, ba, da}, 0);
    check("rst_p", {vp, pp, fp, op, bp, dp}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 1: plain 8N1 word and its latency
    q_a.push_back({8'h55, 1'b0, 1'b0});
    t0 = cyc;
    send(0, 8'h55, 0, 1'b0);
    check("t1_lat_in_155_157",
          (va_cyc - t0 >= 155) && (va_cyc - t0 <= 157), 1);
    check("t1_sb", q_a.size(), 0);

    // 2: even parity, good then bad parity bit
    q_p.push_back({8'hA3, 1'b0, 1'b0});
    send(1, 8'hA3, 1, 1'b0);
    q_p.push_back({8'hA3, 1'b1, 1'b0});
    send(1, 8'hA3, 1, 1'b1);
    check("t2_sb", q_p.size(), 0);

    // 3: false start
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t3_busy_hi", ba, 1);
    rx_a = 1'b1;
    for (int i = 0; i < 12 && ba; i++) begin
      @(posedge clk);
      #1;
    end
    check("t3_busy_lo", ba, 0);
    check("t3_valid", va, 0);
    check("t3_flags", {pa, fa}, 0);

    // 4: break then clean frame
    q_a.push_back({8'h00, 1'b0, 1'b1});
    rx_a = 1'b0;
    repeat (20 * OS) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (2 * OS) @(posedge clk);
    #1;
    check("t4_sb", q_a.size(), 0);
    check("t4_busy", ba, 0);
    q_a.push_back({8'h7E, 1'b0, 1'b0});
    send(0, 8'h7E, 0, 1'b0);
    check("t4_sb2", q_a.size(), 0);

    // 5: overrun with ready low
    ready_a = 1'b0;
    q_a.push_back({8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 0, 1'b0);
    send(0, 8'h22, 0, 1'b0);
    check("t5_valid", va, 1);
    check("t5_data", da, 8'h11);
    check("t5_ovr", oa, 1);
    ready_a = 1'b1;
    @(posedge clk);
    #1 ready_a = 1'b0;
    check("t5_valid_clr", va, 0);
    check("t5_ovr_clr", oa, 0);
    check("t5_sb", q_a.size(), 0);
    ready_a = 1'b1;

    // 6: reset mid-frame
    drive(0, 1'b0, OS);
    drive(0, 1'b1, OS);
    drive(0, 1'b1, OS);
    drive(0, 1'b0, OS);
    drive(0, 1'b0, OS / 2);
    rst = 1'b1;
    #1;
    check("t6_rst_out", {va, pa, fa, oa, ba, da}, 0);
    repeat (2) @(posedge clk);
    #1 rx_a = 1'b1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_idle", {va, ba}, 0);
    q_a.push_back({8'h3C, 1'b0, 1'b0});
    send(0, 8'h3C, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("end_a", q_a.size(), 0);
    check("end_p", q_p.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised successor to the fixed 8N1 receiver: oversampling UART receiver with configurable width, parity and stop bits.
- Adds majority-vote sampling, false-start rejection, parity/framing error flags and overrun detection.
- Delivers words over a valid/ready handshake, so it can feed a FIFO or transmitter without dropping bytes silently.
- Sits between the external RX pin and the hub's buffering logic.

Parameters:
- CLOCK_FREQ, 16000000: system clock in Hz.
- BAUD, 9600: line rate in bit/s.
- WIDTH, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: sample ticks per bit; even, >= 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_in  in  1  asynchronous serial line; idles high.
- data_out  out  WIDTH  received word, LSB = first data bit.
- valid  out  1  data_out and flags hold an unconsumed word.
- ready  in  1  consumer accepts the word when valid && ready at a rising clk edge.
- parity_err  out  1  parity mismatch for the word in data_out.
- frame_err  out  1  a stop bit sampled low for the word in data_out.
- overrun  out  1  sticky; a completed word was dropped because valid was still high.
- busy  out  1  high from start-bit detection until the return to IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0, synchroniser flops 1, FSM = IDLE, counters 0. Asserting rst mid-frame aborts the frame immediately; no partial word is emitted.
- rx_in passes through a 2-flop synchroniser; all logic below uses the synchronised value rx_s.
- Tick generator: DIV = CLOCK_FREQ/(BAUD*OVERSAMPLE), truncated, minimum 1. It emits a one-clk tick every DIV clks and restarts at 0 on start-bit detection.
- Sample counter counts 0..OVERSAMPLE-1 per bit. Bit value = majority of rx_s at sample indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is taken at index OVERSAMPLE/2+1.
- FSM states:
  - IDLE: busy=0. A falling edge on rx_s moves to START.
  - START: majority = 1 means false start, go back to IDLE and emit nothing. Majority = 0 moves to DATA at the end of the bit.
  - DATA: shift WIDTH bits LSB-first. After the last bit, go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY: compute the expected bit (odd: XOR of data inverted; even: XOR of data). A mismatch sets the pending parity error.
  - STOP: sample STOP_BITS bits; any bit that is 0 sets the pending frame error. The word commits at the decision point of the last stop bit, not at the end of that bit, so a back-to-back start edge is caught.
  - After commit: go to IDLE if rx_s=1, otherwise BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s=1, then IDLE. Break or low-line conditions produce exactly one word, with frame_err=1.
- Commit happens 1 clk after the decision tick:
  - valid=0, or valid && ready in that same cycle: load data_out/parity_err/frame_err and set valid=1.
  - valid=1 && ready=0: discard the new word, set overrun=1, leave data_out and the flags unchanged.
- Handshake: when valid && ready with no commit in that cycle, valid goes to 0 on the next edge. The error flags keep their value until the next load. overrun clears on any valid && ready transfer. valid never drops without a transfer.
- Counter widths are sized with CLOG2 of DIV, OVERSAMPLE and WIDTH+3. No counter may wrap inside a frame.

Decomposition:
- uart_pkg holds the CLOG2 function, PARITY_NONE/ODD/EVEN constants and the FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT). The tx successor shares this package.
- Sub-module uart_baud_tick: parametrised divider with synchronous restart input and tick output. The tx side reuses it with OVERSAMPLE=1.

Test Plan:
All benches use CLOCK_FREQ=16000000, BAUD=1000000, OVERSAMPLE=16, so DIV=1 and one bit = 16 clks.
1. 8N1, ready=1, send 0x55 → exactly one word: data_out=0x55 with both error flags 0. valid rises 2+144+9+1 clks after the falling edge, ±1.
2. PARITY=2, send 0xA3 with parity bit 0 → parity_err=0. Repeat with parity bit 1 → data_out=0xA3, parity_err=1.
3. Line pulsed low for 4 clks, then held high → no valid, no errors, and busy returns to 0 within 12 clks.
4. Line held low for 20 bit-times, then released → one word: data_out=0x00, frame_err=1. After release, frame 0x7E is received clean.
5. ready=0, send 0x11 then 0x22 → data_out stays 0x11 and overrun=1. Pulse ready for 1 clk → valid=0 and overrun=0.
6. Assert rst during data bit 3 of 0xC3 → all outputs 0 immediately. After release, frame 0x3C is received with no errors.
